// File: rtl/interfaz_pulsadores_pkg.sv
// Shared definitions for the push-button input peripheral.
// Contents: CPU bus width, interrupt id width, register offsets relative to
// the block base address and the decoded-register enumeration.
package interfaz_pulsadores_pkg;

  localparam int BUS_W = 16;
  localparam int ID_W  = 3;

  localparam logic [BUS_W-1:0] OFF_LEVEL = 16'd0;
  localparam logic [BUS_W-1:0] OFF_PEND  = 16'd1;
  localparam logic [BUS_W-1:0] OFF_MASK  = 16'd2;

  typedef enum logic [1:0] {
    REG_LEVEL = 2'd0,
    REG_PEND  = 2'd1,
    REG_MASK  = 2'd2,
    REG_NONE  = 2'd3
  } reg_sel_e;

endpackage

// File: rtl/interfaz_pulsadores_antirrebote.sv
// One-bit input conditioner: 2-FF synchroniser followed by a debouncer.
// A new level is accepted only after DEB_CYCLES consecutive synchronised
// samples that differ from the current accepted level.
// Ports:
//   clk    in  1  system clock
//   reset  in  1  synchronous, active-low
//   btn    in  1  raw asynchronous button level
//   stable out 1  debounced level
module interfaz_pulsadores_antirrebote
  import interfaz_pulsadores_pkg::*;
#(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic stable
);

  localparam int CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  // Stage p0/p1: metastability synchroniser
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
    end
  end

  // Stage debounce: any sample that agrees with the accepted level restarts
  // the count, so only an uninterrupted run of DEB_CYCLES disagreeing samples
  // moves the level. Reaching the last count always accepts, so no wrap.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (sync_p1 == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      stable <= sync_p1;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/interfaz_pulsadores.sv
// Memory-mapped push-button input peripheral.
// Debounces N_IN buttons, latches rising edges as sticky pending events,
// and raises a masked, prioritised interrupt request.
// Register map (offset from ADDR_BASE): +0 LEVEL (RO), +1 PEND (W1C), +2 MASK (RW).
// Ports:
//   clk       in   1      system clock
//   reset     in   1      synchronous, active-low
//   btn       in   N_IN   raw button levels, 1 = pressed
//   addr      in   16     CPU address
//   data      in   16     CPU write data
//   escritura in   1      CPU write strobe
//   rdata     out  16     combinational read data, 0 when not decoded
//   sel       out  1      combinational address-decode hit
//   irq       out  1      registered |(pend & mask)
//   irq_id    out  3      registered index of lowest pending unmasked bit
module interfaz_pulsadores
  import interfaz_pulsadores_pkg::*;
#(
  parameter int               N_IN       = 4,
  parameter int               DEB_CYCLES = 16,
  parameter logic [BUS_W-1:0] ADDR_BASE  = 16'h0040
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IN-1:0]  btn,
  input  logic [BUS_W-1:0] addr,
  input  logic [BUS_W-1:0] data,
  input  logic             escritura,
  output logic [BUS_W-1:0] rdata,
  output logic             sel,
  output logic             irq,
  output logic [ID_W-1:0]  irq_id
);

  logic [N_IN-1:0]  stable;
  logic [N_IN-1:0]  stable_p1;
  logic [N_IN-1:0]  rise;
  logic [N_IN-1:0]  pend;
  logic [N_IN-1:0]  mask;
  logic [N_IN-1:0]  pend_clr;
  logic [BUS_W-1:0] offset;
  reg_sel_e         reg_sel;
  logic             data_unused;

  // Bus bits above the button count carry no meaning for this block.
  assign data_unused = ^data[BUS_W-1:N_IN];

  function automatic logic [ID_W-1:0] lowest_set(input logic [N_IN-1:0] v);
    logic [ID_W-1:0] idx;
    idx = '0;
    // Scan from the top so the lowest set bit is the last one written.
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (v[i]) idx = ID_W'(i);
    end
    return idx;
  endfunction

  for (genvar i = 0; i < N_IN; i++) begin : g_deb
    interfaz_pulsadores_antirrebote #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk   (clk),
      .reset (reset),
      .btn   (btn[i]),
      .stable(stable[i])
    );
  end

  // Address decode: subtracting the base lets one compare per register
  // cover the whole window without a separate range check.
  assign offset = addr - ADDR_BASE;

  always_comb begin
    reg_sel = REG_NONE;
    if (offset == OFF_LEVEL)     reg_sel = REG_LEVEL;
    else if (offset == OFF_PEND) reg_sel = REG_PEND;
    else if (offset == OFF_MASK) reg_sel = REG_MASK;
  end

  assign sel = (reg_sel != REG_NONE);

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_LEVEL: rdata = BUS_W'(stable);
      REG_PEND:  rdata = BUS_W'(pend);
      REG_MASK:  rdata = BUS_W'(mask);
      default:   rdata = '0;
    endcase
  end

  // Only 0->1 transitions of the debounced level become events.
  assign rise     = stable & ~stable_p1;
  assign pend_clr = (escritura && reg_sel == REG_PEND) ? data[N_IN-1:0] : '0;

  // Stage p1: edge history, event/mask registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      stable_p1 <= '0;
      pend      <= '0;
      mask      <= '0;
    end else begin
      stable_p1 <= stable;
      // OR-ing the new edge after the clear makes a same-cycle set win.
      pend      <= (pend & ~pend_clr) | rise;
      if (escritura && reg_sel == REG_MASK) mask <= data[N_IN-1:0];
    end
  end

  // Stage p2: registered interrupt request and id
  always_ff @(posedge clk) begin
    if (!reset) begin
      irq    <= 1'b0;
      irq_id <= '0;
    end else begin
      irq    <= |(pend & mask);
      irq_id <= lowest_set(pend & mask);
    end
  end

endmodule

// File: tb/tb_interfaz_pulsadores.sv
module tb_interfaz_pulsadores;

  localparam int N_IN = 4;
  localparam int DEB  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  btn = 4'h0;
  logic [15:0] addr = 16'h0000;
  logic [15:0] data = 16'h0000;
  logic        escritura = 1'b0;
  logic [15:0] rdata;
  logic        sel;
  logic        irq;
  logic [2:0]  irq_id;

  interfaz_pulsadores #(
    .N_IN      (N_IN),
    .DEB_CYCLES(DEB),
    .ADDR_BASE (16'h0040)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn      (btn),
    .addr     (addr),
    .data     (data),
    .escritura(escritura),
    .rdata    (rdata),
    .sel      (sel),
    .irq      (irq),
    .irq_id   (irq_id)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string name);
    addr      = a;
    escritura = 1'b0;
    #1;
    check(name, rdata, exp);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    addr      = a;
    data      = d;
    escritura = 1'b1;
    tick();
    escritura = 1'b0;
    data      = 16'h0000;
  endtask

  // ---------------- reference model ----------------
  // Debounced level: a bit flips once the last DEB synchronised observations
  // of that bit, all gathered since its last flip or reset, disagree with it.
  logic [3:0] m_stable, m_stable_prev, m_pend, m_mask, m_s0, m_s1;
  logic       m_irq;
  logic [2:0] m_id;
  logic [3:0] obs_q[$];
  int         since[4];

  function automatic logic [2:0] lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return 3'(i);
    return 3'd0;
  endfunction

  function automatic logic [15:0] m_read(input logic [15:0] a);
    case (a)
      16'h0040: return {12'h000, m_stable};
      16'h0041: return {12'h000, m_pend};
      16'h0042: return {12'h000, m_mask};
      default:  return 16'h0000;
    endcase
  endfunction

  task automatic model_edge(input logic rst_n, input logic [3:0] b, input logic [15:0] a,
                            input logic [15:0] d, input logic we);
    logic [3:0] pm, clr, n_pend, n_stable;
    bool_all: begin end
    if (!rst_n) begin
      m_stable = 0; m_stable_prev = 0; m_pend = 0; m_mask = 0;
      m_s0 = 0; m_s1 = 0; m_irq = 0; m_id = 0;
      obs_q.delete();
      for (int i = 0; i < 4; i++) since[i] = 0;
      return;
    end
    pm     = m_pend & m_mask;
    clr    = (we && a == 16'h0041) ? d[3:0] : 4'h0;
    n_pend = (m_pend & ~clr) | (m_stable & ~m_stable_prev);
    if (we && a == 16'h0042) m_mask = d[3:0];
    m_irq  = |pm;
    m_id   = lowest(pm);
    obs_q.push_back(m_s1);
    if (obs_q.size() > DEB) void'(obs_q.pop_front());
    n_stable = m_stable;
    for (int i = 0; i < 4; i++) begin
      bit all_diff;
      since[i]++;
      all_diff = (since[i] >= DEB) && (obs_q.size() == DEB);
      for (int j = 0; j < DEB && all_diff; j++)
        if (obs_q[j][i] == m_stable[i]) all_diff = 0;
      if (all_diff) begin
        n_stable[i] = ~m_stable[i];
        since[i] = 0;
      end
    end
    m_stable_prev = m_stable;
    m_stable      = n_stable;
    m_pend        = n_pend;
    m_s1          = m_s0;
    m_s0          = b;
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    logic        we;
    logic        exp_sel;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{16'h0040, 16'h0000, 1'b0, 1'b1, 16'h0000};
    tbl[1]  = '{16'h0042, 16'h000A, 1'b1, 1'b1, 16'h0000};
    tbl[2]  = '{16'h0042, 16'h0000, 1'b0, 1'b1, 16'h000A};
    tbl[3]  = '{16'h0043, 16'hFFFF, 1'b1, 1'b0, 16'h0000};
    tbl[4]  = '{16'h003F, 16'hFFFF, 1'b1, 1'b0, 16'h0000};
    tbl[5]  = '{16'h0042, 16'h0000, 1'b0, 1'b1, 16'h000A};
    tbl[6]  = '{16'h0040, 16'hFFFF, 1'b1, 1'b1, 16'h0000};
    tbl[7]  = '{16'h0042, 16'hFFF5, 1'b1, 1'b1, 16'h000A};
    tbl[8]  = '{16'h0042, 16'h0000, 1'b0, 1'b1, 16'h0005};
    tbl[9]  = '{16'h0041, 16'h0000, 1'b0, 1'b1, 16'h0000};
    tbl[10] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000};
    tbl[11] = '{16'h0042, 16'h0000, 1'b1, 1'b1, 16'h0005};
    tbl[12] = '{16'h0042, 16'h0000, 1'b0, 1'b1, 16'h0000};

    // Reset with all buttons held
    reset = 1'b0;
    btn   = 4'hF;
    repeat (2) tick();
    rd(16'h0040, 16'h0000, "rst_level");
    rd(16'h0041, 16'h0000, "rst_pend");
    rd(16'h0042, 16'h0000, "rst_mask");
    check("rst_irq", {15'h0, irq}, 16'h0);
    check("rst_irq_id", {13'h0, irq_id}, 16'h0);
    btn   = 4'h0;
    reset = 1'b1;
    repeat (4) tick();

    // Register map / decode table
    for (int k = 0; k < 13; k++) begin
      addr      = tbl[k].addr;
      data      = tbl[k].data;
      escritura = tbl[k].we;
      #1;
      check($sformatf("tbl%0d_sel", k), {15'h0, sel}, {15'h0, tbl[k].exp_sel});
      check($sformatf("tbl%0d_rdata", k), rdata, tbl[k].exp_rdata);
      tick();
    end
    escritura = 1'b0;

    // Debounce: short pulse rejected, held press accepted after 2+DEB cycles
    btn = 4'h2;
    repeat (3) tick();
    btn = 4'h0;
    repeat (8) tick();
    rd(16'h0040, 16'h0000, "glitch_level");
    rd(16'h0041, 16'h0000, "glitch_pend");
    btn = 4'h2;
    repeat (5) tick();
    rd(16'h0040, 16'h0000, "deb_level_early");
    tick();
    rd(16'h0040, 16'h0002, "deb_level_cycle6");
    rd(16'h0041, 16'h0000, "deb_pend_not_yet");
    tick();
    rd(16'h0041, 16'h0002, "deb_pend_set");
    check("deb_irq_masked", {15'h0, irq}, 16'h0);
    repeat (3) tick();
    btn = 4'h0;
    repeat (8) tick();
    rd(16'h0040, 16'h0000, "release_level");
    rd(16'h0041, 16'h0002, "falling_not_latched");

    // IRQ path
    wr(16'h0041, 16'h0002);
    rd(16'h0041, 16'h0000, "w1c_pend");
    wr(16'h0042, 16'h0002);
    rd(16'h0042, 16'h0002, "mask_write");
    repeat (2) tick();
    check("irq_idle", {15'h0, irq}, 16'h0);
    btn = 4'h2;
    repeat (7) tick();
    check("irq_early", {15'h0, irq}, 16'h0);
    tick();
    check("irq_set", {15'h0, irq}, 16'h1);
    check("irq_id_1", {13'h0, irq_id}, 16'h1);
    btn = 4'h0;
    wr(16'h0041, 16'h0002);
    rd(16'h0041, 16'h0000, "irq_pend_cleared");
    check("irq_lags_pend", {15'h0, irq}, 16'h1);
    tick();
    check("irq_cleared", {15'h0, irq}, 16'h0);

    // Priority
    repeat (8) tick();
    wr(16'h0042, 16'h000F);
    btn = 4'hC;
    repeat (8) tick();
    check("prio_irq", {15'h0, irq}, 16'h1);
    check("prio_id_2", {13'h0, irq_id}, 16'h2);
    btn = 4'h0;
    wr(16'h0041, 16'h0004);
    tick();
    check("prio_id_3", {13'h0, irq_id}, 16'h3);
    wr(16'h0041, 16'h0008);
    tick();
    check("prio_irq_off", {15'h0, irq}, 16'h0);
    check("prio_id_off", {13'h0, irq_id}, 16'h0);

    // Same-cycle set and W1C clear: the set wins
    repeat (8) tick();
    btn = 4'h1;
    repeat (6) tick();
    rd(16'h0040, 16'h0001, "coll_level");
    rd(16'h0041, 16'h0000, "coll_pend_before");
    addr      = 16'h0041;
    data      = 16'h0001;
    escritura = 1'b1;
    tick();
    escritura = 1'b0;
    rd(16'h0041, 16'h0001, "coll_set_wins");
    tick();
    check("coll_irq", {15'h0, irq}, 16'h1);
    check("coll_id_0", {13'h0, irq_id}, 16'h0);
    wr(16'h0041, 16'h0001);
    rd(16'h0041, 16'h0000, "coll_clear_after");
    btn = 4'h0;
    repeat (8) tick();

    // Randomised run against the reference model
    reset = 1'b0;
    model_edge(1'b0, btn, addr, data, escritura);
    tick();
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] alist[6];
      reset = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 2) == 0) btn[$urandom_range(0, 3)] ^= 1'b1;
      alist[0] = 16'h003F; alist[1] = 16'h0040; alist[2] = 16'h0041;
      alist[3] = 16'h0042; alist[4] = 16'h0043; alist[5] = 16'($urandom);
      addr      = alist[$urandom_range(0, 5)];
      data      = 16'($urandom);
      escritura = ($urandom_range(0, 3) == 0);
      #1;
      check("rnd_sel", {15'h0, sel},
            {15'h0, (addr >= 16'h0040 && addr <= 16'h0042)});
      check("rnd_rdata", rdata, m_read(addr));
      model_edge(reset, btn, addr, data, escritura);
      tick();
      check("rnd_irq", {15'h0, irq}, {15'h0, m_irq});
      check("rnd_irq_id", {13'h0, irq_id}, {13'h0, m_id});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
